// File: rtl/swire_pkg.sv
// Shared definitions for the single-wire responder: FSM states and frame constants.
package swire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    TURN,
    TX_START,
    TX_DATA,
    TX_STOP
  } state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/swire_bit_timer.sv
// Free-running bit-period counter with synchronous clear.
// Flags the mid-bit cycle and the last cycle of each bit period.
module swire_bit_timer #(
  parameter int BIT_CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic mid_tick,
  output logic end_tick
);

  localparam int W = $clog2(BIT_CYCLES);

  logic [W-1:0] cnt;

  assign mid_tick = (cnt == W'(BIT_CYCLES / 2 - 1));
  assign end_tick = (cnt == W'(BIT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || end_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/swire_responder.sv
// Half-duplex single-wire responder: receives one UART-style command frame,
// releases the line for a guard interval, then drives back one response frame.
module swire_responder
  import swire_pkg::*;
#(
  parameter int BIT_CYCLES = 100,
  parameter int TURN_BITS  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dout,
  output logic       en,
  output logic       din,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_done,
  output logic       no_resp,
  output logic       busy
);

  localparam int TW = $clog2(TURN_BITS + 1);

  state_t          state;
  logic            sync1, line_s, prev_line;
  logic [7:0]      rx_shift, tx_shift;
  logic [2:0]      bit_idx;
  logic [TW-1:0]   turn_cnt;
  logic            timer_clr, mid_tick, end_tick, fall, turn_last;

  // After the start bit is confirmed at mid-bit the timer is re-zeroed, so
  // every later end_tick lands in the middle of a received bit.
  assign timer_clr = (state == IDLE) || ((state == RX_START) && mid_tick);
  assign fall      = prev_line && !line_s;
  assign turn_last = (state == TURN) && end_tick && (turn_cnt == TW'(TURN_BITS - 1));
  assign busy      = (state != IDLE);

  swire_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timer_clr),
    .mid_tick (mid_tick),
    .end_tick (end_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      line_s <= 1'b1;
    end else begin
      sync1  <= dout;
      line_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en        <= 1'b0;
      din       <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      no_resp   <= 1'b0;
      tx_done   <= 1'b0;
      prev_line <= 1'b1;
      rx_shift  <= '0;
      tx_shift  <= '0;
      bit_idx   <= '0;
      turn_cnt  <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      no_resp   <= 1'b0;
      tx_done   <= 1'b0;
      prev_line <= line_s;
      case (state)
        IDLE: begin
          if (fall) state <= RX_START;
        end
        RX_START: begin
          if (mid_tick) begin
            if (line_s == START_BIT) begin
              bit_idx <= '0;
              state   <= RX_DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        RX_DATA: begin
          if (end_tick) begin
            rx_shift <= {line_s, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= RX_STOP;
          end
        end
        // A bad stop leaves prev_line tracking the (low) line, so a fresh
        // falling edge is required before the next frame is accepted.
        RX_STOP: begin
          if (end_tick) begin
            if (line_s == STOP_BIT) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              turn_cnt <= '0;
              state    <= TURN;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        TURN: begin
          if (end_tick) turn_cnt <= turn_cnt + 1'b1;
          if (turn_last) begin
            if (tx_valid) begin
              tx_shift <= tx_data;
              en       <= 1'b1;
              din      <= START_BIT;
              state    <= TX_START;
            end else begin
              no_resp   <= 1'b1;
              prev_line <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        TX_START: begin
          if (end_tick) begin
            din     <= tx_shift[0];
            bit_idx <= '0;
            state   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (end_tick) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              din   <= STOP_BIT;
              state <= TX_STOP;
            end else begin
              tx_shift <= {1'b0, tx_shift[7:1]};
              din      <= tx_shift[1];
            end
          end
        end
        TX_STOP: begin
          if (end_tick) begin
            en        <= 1'b0;
            din       <= 1'b1;
            tx_done   <= 1'b1;
            prev_line <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swire_responder.sv
// Bench for swire_responder: an initiator model drives the shared line and a
// cycle-timeline model predicts every output from the frame arithmetic.
module tb_swire_responder;

  localparam int B = 100;
  localparam int T = 2;

  localparam int K_NONE   = 0;
  localparam int K_RESP   = 1;
  localparam int K_NORESP = 2;
  localparam int K_ERR    = 3;
  localparam int K_FALSE  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en, din, rx_valid, frame_err, tx_done, no_resp, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       init_drv = 1'b0;
  logic       init_val = 1'b1;
  logic       line;

  assign line = en ? din : (init_drv ? init_val : 1'b1);

  swire_responder #(.BIT_CYCLES(B), .TURN_BITS(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dout      (line),
    .en        (en),
    .din       (din),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_done   (tx_done),
    .no_resp   (no_resp),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Timeline model state: start cycle of the current frame and its outcome.
  int         m_k = -100000;
  int         m_kind = K_NONE;
  logic [7:0] m_cmd = 8'h00;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] model_rx = 8'h00;
  bit         in_reset = 1'b1;

  bit         wiggle = 1'b0;
  int         cap_cyc = -1;
  logic       want_v = 1'b0;
  logic [7:0] want_d = 8'h00;

  int en_cycles = 0;
  int busy_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (en) en_cycles++;
    if (busy) busy_cycles++;
  end

  // Randomised response inputs everywhere except the capture cycle.
  always @(negedge clk) begin
    if (wiggle) begin
      if (cyc == cap_cyc) begin
        tx_valid = want_v;
        tx_data  = want_d;
      end else begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom_range(0, 255));
      end
    end
  end

  // Per-cycle compare against the timeline model.
  always @(negedge clk) begin : cmp
    int st, r, tx0, td, bend, o;
    logic en_e, din_e, busy_e, rxv_e, fe_e, nr_e, td_e;
    st  = m_k + 3;
    r   = st + B / 2 + 9 * B;
    tx0 = r + T * B;
    td  = tx0 + 10 * B;
    case (m_kind)
      K_RESP:   bend = td;
      K_NORESP: bend = tx0;
      K_ERR:    bend = r;
      K_FALSE:  bend = st + B / 2;
      default:  bend = st;
    endcase
    busy_e = (m_kind != K_NONE) && (cyc >= st) && (cyc < bend);
    rxv_e  = ((m_kind == K_RESP) || (m_kind == K_NORESP)) && (cyc == r);
    fe_e   = (m_kind == K_ERR) && (cyc == r);
    nr_e   = (m_kind == K_NORESP) && (cyc == tx0);
    td_e   = (m_kind == K_RESP) && (cyc == td);
    en_e   = (m_kind == K_RESP) && (cyc >= tx0) && (cyc < td);
    din_e  = 1'b1;
    if (en_e) begin
      o = (cyc - tx0) / B;
      if (o == 0) din_e = 1'b0;
      else if (o <= 8) din_e = m_tx[o-1];
    end
    if (in_reset) begin
      {en_e, din_e, busy_e, rxv_e, fe_e, nr_e, td_e} = 7'b0100000;
      model_rx = 8'h00;
    end else if (rxv_e) begin
      model_rx = m_cmd;
    end
    check("outputs", {17'd0, en, din, busy, rx_valid, frame_err, no_resp, tx_done, rx_data},
          {17'd0, en_e, din_e, busy_e, rxv_e, fe_e, nr_e, td_e, model_rx});
    check("contention", {31'd0, en & init_drv}, 32'd0);
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input bit bad_stop);
    logic [9:0] bits;
    bits = {~bad_stop, cmd, 1'b0};
    init_drv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      init_val = bits[i];
      repeat (B) @(negedge clk);
    end
    init_drv = 1'b0;
    init_val = 1'b1;
  endtask

  // Initiator-side receiver: finds the start edge and samples mid-bit.
  task automatic capture(output logic [7:0] got, output bit ok);
    int n;
    n = 0;
    got = 8'h00;
    ok = 1'b0;
    while (line !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (line !== 1'b0) return;
    repeat (B / 2) @(negedge clk);
    if (line !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(negedge clk);
      got[i] = line;
    end
    repeat (B) @(negedge clk);
    ok = (line === 1'b1);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input bit bad, input bit v,
                           input logic [7:0] d, input bit wig, input int abort_off,
                           output logic [7:0] got);
    logic [7:0] g;
    bit ok;
    int tx0;
    got = 8'h00;
    @(negedge clk);
    m_k    = cyc;
    m_kind = bad ? K_ERR : (v ? K_RESP : K_NORESP);
    m_cmd  = cmd;
    m_tx   = d;
    tx0    = m_k + 3 + B / 2 + 9 * B + T * B;
    want_v = v;
    want_d = d;
    cap_cyc = tx0 - 1;
    en_cycles = 0;
    if (wig) wiggle = 1'b1;
    else begin
      tx_valid = v;
      tx_data  = d;
    end
    send_frame(cmd, bad);
    if (abort_off >= 0) begin
      wait_until(tx0 + abort_off);
      wiggle = 1'b0;
      return;
    end
    if (m_kind == K_RESP) begin
      capture(g, ok);
      got = g;
      check("resp_frame_ok", {31'd0, ok}, 32'd1);
      check("resp_byte", {24'd0, g}, {24'd0, d});
    end
    wait_until(tx0 + 10 * B + 20);
    wiggle = 1'b0;
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    m_k = cyc;
    m_kind = K_FALSE;
    busy_cycles = 0;
    init_drv = 1'b1;
    init_val = 1'b0;
    repeat (len) @(negedge clk);
    init_val = 1'b1;
    init_drv = 1'b0;
    wait_until(m_k + 3 * B);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] rc, rd;
    bit rbad, rv;

    repeat (3) @(negedge clk);
    check("reset_en", {31'd0, en}, 32'd0);
    check("reset_din", {31'd0, din}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    #2;
    rst_n = 1'b1;
    in_reset = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(8'hA5, 1'b0, 1'b1, 8'h3C, 1'b0, -1, got);
    check("a5_rx_data", {24'd0, rx_data}, 32'hA5);
    check("a5_resp", {24'd0, got}, 32'h3C);
    check("a5_en_len", en_cycles, 32'd1000);

    run_frame(8'h00, 1'b0, 1'b1, 8'hC3, 1'b0, -1, got);
    check("zero_rx_data", {24'd0, rx_data}, 32'h00);
    check("zero_resp", {24'd0, got}, 32'hC3);

    run_frame(8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, -1, got);
    check("ff_rx_data", {24'd0, rx_data}, 32'hFF);
    check("ff_resp", {24'd0, got}, 32'h00);

    run_frame(8'h5A, 1'b1, 1'b1, 8'h77, 1'b0, -1, got);
    check("err_rx_kept", {24'd0, rx_data}, 32'hFF);
    check("err_no_drive", en_cycles, 32'd0);

    glitch(10);
    check("glitch_busy_len", busy_cycles, 32'd50);
    check("glitch_rx_kept", {24'd0, rx_data}, 32'hFF);

    run_frame(8'h6E, 1'b0, 1'b0, 8'h55, 1'b0, -1, got);
    check("noresp_rx_data", {24'd0, rx_data}, 32'h6E);
    check("noresp_no_drive", en_cycles, 32'd0);

    run_frame(8'h11, 1'b0, 1'b1, 8'hEE, 1'b0, -1, got);
    check("after_noresp_rx", {24'd0, rx_data}, 32'h11);
    check("after_noresp_resp", {24'd0, got}, 32'hEE);

    run_frame(8'h77, 1'b0, 1'b1, 8'h99, 1'b0, 450, got);
    @(posedge clk);
    #2;
    in_reset = 1'b1;
    m_kind = K_NONE;
    rst_n = 1'b0;
    #1;
    check("async_en", {31'd0, en}, 32'd0);
    check("async_din", {31'd0, din}, 32'd1);
    check("async_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    in_reset = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(8'h42, 1'b0, 1'b1, 8'h24, 1'b0, -1, got);
    check("post_reset_rx", {24'd0, rx_data}, 32'h42);
    check("post_reset_resp", {24'd0, got}, 32'h24);

    for (int i = 0; i < 6; i++) begin
      rc   = 8'($urandom_range(0, 255));
      rd   = 8'($urandom_range(0, 255));
      rbad = ($urandom_range(0, 4) == 0);
      rv   = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 40)) @(negedge clk);
      run_frame(rc, rbad, rv, rd, 1'b1, -1, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
